// File: rtl/scanner_pkg.sv
// Shared types for the set-bit scanner: scan direction and FSM state encodings.
package scanner_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/find_first_set.sv
// Combinational priority finder: first set bit of vec, scanning from MSB (DIR_LEFT) or LSB (DIR_RIGHT).
module find_first_set
    import scanner_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  dir_e             dir,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             found
);

    // The first hit in scan order wins; later hits are masked by found.
    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (dir == DIR_RIGHT) begin
                if (!found && vec[i]) begin
                    found     = 1'b1;
                    idx       = IDX_W'(i);
                    onehot[i] = 1'b1;
                end
            end else begin
                if (!found && vec[WIDTH-1-i]) begin
                    found             = 1'b1;
                    idx               = IDX_W'(WIDTH-1-i);
                    onehot[WIDTH-1-i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/set_bit_scanner.sv
// Accepts a word, then emits one beat per set bit (MSB- or LSB-first) over a valid/ready stream.
module set_bit_scanner
    import scanner_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned IDX_W = $clog2(WIDTH),
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic [WIDTH-1:0] bit_onehot_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             bit_last_o,
    output logic             bit_empty_o
);

    state_e             state, state_nxt;
    dir_e               dir_q, dir_nxt;
    logic [WIDTH-1:0]   shadow, shadow_nxt;
    logic [CNT_W-1:0]   ord, ord_nxt;

    logic [IDX_W-1:0]   ffs_idx;
    logic [WIDTH-1:0]   ffs_onehot;
    logic               ffs_found;
    logic               scan;
    logic               multi_bit;
    logic               accept;
    logic               beat_hs;

    find_first_set #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_ffs (
        .vec    (shadow),
        .dir    (dir_q),
        .idx    (ffs_idx),
        .onehot (ffs_onehot),
        .found  (ffs_found)
    );

    // Output beat is decoded purely from registered state; no path from data_i.
    assign scan         = (state == ST_SCAN);
    assign multi_bit    = |(shadow & (shadow - WIDTH'(1)));
    assign data_ready_o = arstn_i & (state == ST_IDLE);
    assign bit_valid_o  = scan;
    assign bit_idx_o    = scan ? ffs_idx : '0;
    assign bit_onehot_o = scan ? ffs_onehot : '0;
    assign bit_cnt_o    = (scan && ffs_found) ? ord : '0;
    assign bit_last_o   = scan & ~multi_bit;
    assign bit_empty_o  = scan & ~ffs_found;

    assign accept  = data_valid_i & data_ready_o;
    assign beat_hs = bit_valid_o & bit_ready_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state  <= ST_IDLE;
            dir_q  <= DIR_LEFT;
            shadow <= '0;
            ord    <= '0;
        end else begin
            state  <= state_nxt;
            dir_q  <= dir_nxt;
            shadow <= shadow_nxt;
            ord    <= ord_nxt;
        end
    end

    // Ordinal is not advanced on the last beat so it never exceeds WIDTH.
    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_q;
        shadow_nxt = shadow;
        ord_nxt    = ord;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt  = ST_SCAN;
                    shadow_nxt = data_i;
                    dir_nxt    = dir_e'(dir_i);
                    ord_nxt    = CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (beat_hs) begin
                    shadow_nxt = shadow & ~ffs_onehot;
                    if (bit_last_o) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        ord_nxt = ord + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench for set_bit_scanner at WIDTH=5 and WIDTH=16 with hand-computed beats.
module tb_set_bit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [4:0]  d5;
    logic        dir5, dv5, rdy5, bv5, br5, last5, empty5;
    logic [2:0]  idx5, cnt5;
    logic [4:0]  oh5;

    logic [15:0] d16;
    logic        dir16, dv16, rdy16, bv16, br16, last16, empty16;
    logic [3:0]  idx16;
    logic [4:0]  cnt16;
    logic [15:0] oh16;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    set_bit_scanner #(.WIDTH(5)) u_w5 (
        .clk_i(clk), .arstn_i(rst_n), .data_i(d5), .dir_i(dir5),
        .data_valid_i(dv5), .data_ready_o(rdy5), .bit_valid_o(bv5), .bit_ready_i(br5),
        .bit_idx_o(idx5), .bit_onehot_o(oh5), .bit_cnt_o(cnt5),
        .bit_last_o(last5), .bit_empty_o(empty5)
    );

    set_bit_scanner #(.WIDTH(16)) u_w16 (
        .clk_i(clk), .arstn_i(rst_n), .data_i(d16), .dir_i(dir16),
        .data_valid_i(dv16), .data_ready_o(rdy16), .bit_valid_o(bv16), .bit_ready_i(br16),
        .bit_idx_o(idx16), .bit_onehot_o(oh16), .bit_cnt_o(cnt16),
        .bit_last_o(last16), .bit_empty_o(empty16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat5(input string tag, input int idx, input int oh, input int cnt,
                         input bit last, input bit empty);
        chk({tag, ".valid5"}, 64'(bv5), 64'd1);
        chk({tag, ".ready5"}, 64'(rdy5), 64'd0);
        chk({tag, ".idx5"},   64'(idx5), 64'(idx));
        chk({tag, ".oh5"},    64'(oh5), 64'(oh));
        chk({tag, ".cnt5"},   64'(cnt5), 64'(cnt));
        chk({tag, ".last5"},  64'(last5), 64'(last));
        chk({tag, ".empty5"}, 64'(empty5), 64'(empty));
    endtask

    task automatic beat16(input string tag, input int idx, input int oh, input int cnt,
                          input bit last, input bit empty);
        chk({tag, ".valid16"}, 64'(bv16), 64'd1);
        chk({tag, ".ready16"}, 64'(rdy16), 64'd0);
        chk({tag, ".idx16"},   64'(idx16), 64'(idx));
        chk({tag, ".oh16"},    64'(oh16), 64'(oh));
        chk({tag, ".cnt16"},   64'(cnt16), 64'(cnt));
        chk({tag, ".last16"},  64'(last16), 64'(last));
        chk({tag, ".empty16"}, 64'(empty16), 64'(empty));
    endtask

    task automatic idle5(input string tag);
        chk({tag, ".valid5"}, 64'(bv5), 64'd0);
        chk({tag, ".ready5"}, 64'(rdy5), 64'd1);
    endtask

    task automatic idle16(input string tag);
        chk({tag, ".valid16"}, 64'(bv16), 64'd0);
        chk({tag, ".ready16"}, 64'(rdy16), 64'd1);
    endtask

    // Present a word for one cycle, then scramble data/dir to show they are ignored in SCAN.
    task automatic send5(input logic [4:0] w, input logic dir);
        chk("send5.ready", 64'(rdy5), 64'd1);
        d5 = w; dir5 = dir; dv5 = 1'b1;
        tick;
        dv5 = 1'b0; d5 = ~w; dir5 = ~dir;
    endtask

    task automatic send16(input logic [15:0] w, input logic dir);
        chk("send16.ready", 64'(rdy16), 64'd1);
        d16 = w; dir16 = dir; dv16 = 1'b1;
        tick;
        dv16 = 1'b0; d16 = ~w; dir16 = ~dir;
    endtask

    initial begin
        logic [4:0] wv;
        int         b;
        int         nb;
        bit         hs;
        int         tries;

        rst_n = 1'b0;
        d5 = '0; dir5 = 1'b0; dv5 = 1'b0; br5 = 1'b1;
        d16 = '0; dir16 = 1'b0; dv16 = 1'b0; br16 = 1'b1;
        tick;
        tick;

        // Outputs held at zero during reset
        chk("rst.ready5", 64'(rdy5), 64'd0);
        chk("rst.valid5", 64'(bv5), 64'd0);
        chk("rst.ready16", 64'(rdy16), 64'd0);
        chk("rst.valid16", 64'(bv16), 64'd0);
        chk("rst.idx16", 64'(idx16), 64'd0);
        chk("rst.oh16", 64'(oh16), 64'd0);
        chk("rst.cnt16", 64'(cnt16), 64'd0);
        chk("rst.last16", 64'(last16), 64'd0);
        chk("rst.empty16", 64'(empty16), 64'd0);
        rst_n = 1'b1;
        #1;
        idle5("rel");
        idle16("rel");

        // MSB-first 00110 with a mid-word data_valid that must be ignored
        send5(5'b00110, 1'b0);
        beat5("w00110.b1", 2, 5'b00100, 1, 1'b0, 1'b0);
        dv5 = 1'b1; d5 = 5'b11111; dir5 = 1'b1;
        tick;
        beat5("w00110.b2", 1, 5'b00010, 2, 1'b1, 1'b0);
        dv5 = 1'b0;
        tick;
        idle5("w00110.bubble");

        // LSB-first all-ones: WIDTH beats, last only on the final one
        send5(5'b11111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat5("w11111", i, 1 << i, i + 1, i == 4, 1'b0);
            tick;
        end
        idle5("w11111.bubble");

        // Zero word: single empty beat
        send5(5'b00000, 1'b0);
        beat5("w00000", 0, 0, 0, 1'b1, 1'b1);
        tick;
        idle5("w00000.bubble");

        // 0x8001 MSB-first with 3 stall cycles on the first beat
        send16(16'h8001, 1'b0);
        br16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat16("w8001.stall", 15, 16'h8000, 1, 1'b0, 1'b0);
            tick;
        end
        br16 = 1'b1;
        beat16("w8001.b1", 15, 16'h8000, 1, 1'b0, 1'b0);
        tick;
        beat16("w8001.b2", 0, 16'h0001, 2, 1'b1, 1'b0);
        tick;
        idle16("w8001.bubble");

        // Reset in the middle of 0x00F0
        send16(16'h00F0, 1'b0);
        beat16("w00f0.b1", 7, 16'h0080, 1, 1'b0, 1'b0);
        tick;
        beat16("w00f0.b2", 6, 16'h0040, 2, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.ready16", 64'(rdy16), 64'd0);
        chk("midrst.valid16", 64'(bv16), 64'd0);
        chk("midrst.idx16", 64'(idx16), 64'd0);
        chk("midrst.oh16", 64'(oh16), 64'd0);
        chk("midrst.cnt16", 64'(cnt16), 64'd0);
        chk("midrst.last16", 64'(last16), 64'd0);
        chk("midrst.empty16", 64'(empty16), 64'd0);
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        idle16("midrst.rel");
        send16(16'h0001, 1'b0);
        beat16("w0001", 0, 16'h0001, 1, 1'b1, 1'b0);
        tick;
        idle16("w0001.bubble");

        // Every 5-bit word, both directions, with random backpressure
        for (int dr = 0; dr < 2; dr++) begin
            for (int w = 0; w < 32; w++) begin
                wv = 5'(w);
                exp_q.delete();
                for (int k = 0; k < 5; k++) begin
                    b = (dr == 0) ? 4 - k : k;
                    if (wv[b]) exp_q.push_back(b);
                end
                nb = (exp_q.size() == 0) ? 1 : exp_q.size();
                send5(wv, 1'(dr));
                for (int j = 0; j < nb; j++) begin
                    hs = 1'b0;
                    tries = 0;
                    while (!hs && tries < 16) begin
                        br5 = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                        if (w == 0) beat5("exh.zero", 0, 0, 0, 1'b1, 1'b1);
                        else beat5("exh", exp_q[j], 1 << exp_q[j], j + 1, j == nb - 1, 1'b0);
                        hs = br5 && bv5;
                        tick;
                        tries++;
                    end
                    chk("exh.handshake", 64'(hs), 64'd1);
                end
                idle5("exh.bubble");
                br5 = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
